// File: rtl/bus_pkg.sv
// Shared definitions for the bus multiplexer: default widths and the
// datapath source numbering used when the mux feeds the CPU bus.
package bus_pkg;

  localparam int BUS_WIDTH_DEF = 32;
  localparam int CNT_WIDTH_DEF = 16;
  localparam int MIN_SOURCES   = 2;
  localparam int MAX_SOURCES   = 64;

  // Source numbering for the datapath instance: general registers first,
  // then special registers, then the external/condition sources.
  typedef enum logic [4:0] {
    R0, R1, R2, R3, R4, R5, R6, R7,
    R8, R9, R10, R11, R12, R13, R14, R15,
    HI, LO, ZHI, ZLO, PC, MDR, INPORT, C_SIGN
  } src_e;

  localparam int DATAPATH_SOURCES = 24;

endpackage : bus_pkg

// File: rtl/onehot_prio_enc.sv
// Combinational lowest-index priority encoder with "any" and "more than one"
// flags; used to pick the bus winner and detect driver contention.
module onehot_prio_enc #(
  parameter int N = 32
) (
  input  logic [N-1:0]         req,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any,
  output logic                 multi
);

  localparam int SELW = $clog2(N);

  logic [N-1:0] req_minus_one;

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    idx = '0;
    // Scanning downwards lets the lowest set index overwrite higher ones.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = SELW'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves something behind only if two or more
  // bits were set.
  assign req_minus_one = req - {{(N-1){1'b0}}, 1'b1};
  assign any           = |req;
  assign multi         = |(req & req_minus_one);

endmodule : onehot_prio_enc

// File: rtl/bus_mux_reg.sv
// Registered N-source bus multiplexer with bus keeper, hold, and contention
// detection (pulse, sticky flag and saturating counter).
module bus_mux_reg
  import bus_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH_DEF,
  parameter int N     = 32,
  parameter int CNTW  = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         drive,
  input  logic [N*WIDTH-1:0]   data_in,
  input  logic                 hold,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     bus_out,
  output logic                 bus_valid,
  output logic [$clog2(N)-1:0] src_id,
  output logic                 contention,
  output logic                 err_sticky,
  output logic [CNTW-1:0]      contention_cnt
);

  localparam int SELW = $clog2(N);

  logic [SELW-1:0]  enc_idx;
  logic             enc_any;
  logic             enc_multi;
  logic [WIDTH-1:0] sel_word;
  logic             contend;

  logic [WIDTH-1:0] bus_q,   bus_d;
  logic [SELW-1:0]  src_q,   src_d;
  logic             valid_q, valid_d;
  logic             cont_q,  cont_d;
  logic             err_q,   err_d;
  logic [CNTW-1:0]  cnt_q,   cnt_d;

  onehot_prio_enc #(
    .N (N)
  ) u_enc (
    .req   (drive),
    .idx   (enc_idx),
    .any   (enc_any),
    .multi (enc_multi)
  );

  // Only the winning source's word reaches the bus; the encoder never
  // produces an index at or above N, so no out-of-range slice exists.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N; i++) begin
      if (enc_idx == SELW'(i)) begin
        sel_word = data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  assign contend = !hold && enc_multi;

  always_comb begin
    bus_d   = bus_q;
    src_d   = src_q;
    valid_d = valid_q;
    cont_d  = cont_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    if (!hold) begin
      valid_d = enc_any;
      cont_d  = enc_multi;
      if (enc_any) begin
        bus_d = sel_word;
        src_d = enc_idx;
      end
    end

    // A contention in the clearing cycle is the first event of the new epoch.
    if (clr_err) begin
      err_d = contend;
      cnt_d = contend ? CNTW'(1) : '0;
    end else if (contend) begin
      err_d = 1'b1;
      if (cnt_q != {CNTW{1'b1}}) begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_q   <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
      cont_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      bus_q   <= bus_d;
      src_q   <= src_d;
      valid_q <= valid_d;
      cont_q  <= cont_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus_out        = bus_q;
  assign bus_valid      = valid_q;
  assign src_id         = src_q;
  assign contention     = cont_q;
  assign err_sticky     = err_q;
  assign contention_cnt = cnt_q;

endmodule : bus_mux_reg
